// File: rtl/c1_cycle_ctrl.sv
// 68K bus cycle controller: zone-based wait-state insertion, external ack with
// timeout to bus error, and a sticky timeout flag. State advances on CLK_68KCLK falling edge.
module c1_cycle_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic CLK_68KCLK,
    input  logic nRESET,
    input  logic nAS,
    input  logic nROM_ZONE,
    input  logic nPORT_ZONE,
    input  logic nCARD_ZONE,
    input  logic nROMWAIT,
    input  logic nPWAIT0,
    input  logic nPWAIT1,
    input  logic PDTACK,
    input  logic TO_CLR,
    output logic nDTACK,
    output logic nBERR,
    output logic BUSY,
    output logic TIMEOUT_FLAG
);

    localparam int unsigned WCNT_W = 2;
    localparam int unsigned TCNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_EXT  = 3'd2,
        ST_ACK  = 3'd3,
        ST_BERR = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                ack_q, ack_d;
    logic                berr_q, berr_d;
    logic                flag_q, flag_d;

    logic [WCNT_W-1:0]   port_code_c;
    logic [WCNT_W-1:0]   dec_wait_c;
    logic                dec_ext_c;
    logic                tmo_hit_c;

    assign port_code_c = {~nPWAIT0, ~nPWAIT1};
    assign tmo_hit_c   = (({1'b0, tcnt_q} + 5'd1) == 5'(TIMEOUT));

    // Zone/wait decode, priority ROM > PORT > CARD > none; only consumed in IDLE
    always_comb begin
        dec_wait_c = '0;
        dec_ext_c  = 1'b0;
        if (!nROM_ZONE) begin
            dec_wait_c = nROMWAIT ? WCNT_W'(0) : WCNT_W'(1);
        end else if (!nPORT_ZONE) begin
            if (port_code_c == 2'd3) begin
                dec_ext_c = 1'b1;
            end else begin
                dec_wait_c = port_code_c;
            end
        end else if (!nCARD_ZONE) begin
            dec_wait_c = WCNT_W'(2);
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        flag_d  = flag_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!nAS) begin
                    if (dec_ext_c) begin
                        state_d = ST_EXT;
                        tcnt_d  = '0;
                    end else if (dec_wait_c == '0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = dec_wait_c;
                    end
                end
            end
            ST_WAIT: begin
                if (nAS) begin
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(1)) begin
                    state_d = ST_ACK;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d  = wcnt_q - WCNT_W'(1);
                end
            end
            ST_EXT: begin
                // Aborted strobe first, then device ack beats a coincident timeout
                if (nAS) begin
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                end else if (PDTACK) begin
                    state_d = ST_ACK;
                    tcnt_d  = '0;
                end else if (tmo_hit_c) begin
                    state_d = ST_BERR;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d  = tcnt_q + TCNT_W'(1);
                end
            end
            ST_ACK, ST_BERR: begin
                if (nAS) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = '0;
                tcnt_d  = '0;
            end
        endcase

        ack_d  = (state_d == ST_ACK);
        berr_d = (state_d == ST_BERR);

        // Set wins over a same-edge clear
        if (TO_CLR) begin
            flag_d = 1'b0;
        end
        if (state_q == ST_EXT && state_d == ST_BERR) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(negedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            ack_q   <= 1'b0;
            berr_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            ack_q   <= ack_d;
            berr_q  <= berr_d;
            flag_q  <= flag_d;
        end
    end

    // Strobe gating lets the acknowledge drop the instant nAS rises
    assign nDTACK       = nAS | ~ack_q;
    assign nBERR        = nAS | ~berr_q;
    assign BUSY         = (state_q != ST_IDLE);
    assign TIMEOUT_FLAG = flag_q;

endmodule

// File: tb/tb_c1_cycle_ctrl.sv
// Directed bench for c1_cycle_ctrl (TIMEOUT = 4); expected values hand-derived
// from the edge numbering E0 = first falling edge with nAS sampled low.
module tb_c1_cycle_ctrl;

    logic clk = 1'b1;
    logic nRESET, nAS, nROM_ZONE, nPORT_ZONE, nCARD_ZONE, nROMWAIT;
    logic nPWAIT0, nPWAIT1, PDTACK, TO_CLR;
    logic nDTACK, nBERR, BUSY, TIMEOUT_FLAG;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    c1_cycle_ctrl #(.TIMEOUT(4)) dut (
        .CLK_68KCLK  (clk),
        .nRESET      (nRESET),
        .nAS         (nAS),
        .nROM_ZONE   (nROM_ZONE),
        .nPORT_ZONE  (nPORT_ZONE),
        .nCARD_ZONE  (nCARD_ZONE),
        .nROMWAIT    (nROMWAIT),
        .nPWAIT0     (nPWAIT0),
        .nPWAIT1     (nPWAIT1),
        .PDTACK      (PDTACK),
        .TO_CLR      (TO_CLR),
        .nDTACK      (nDTACK),
        .nBERR       (nBERR),
        .BUSY        (BUSY),
        .TIMEOUT_FLAG(TIMEOUT_FLAG)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance past one active (falling) edge; outputs settle before sampling
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic zones(input logic rom, input logic port, input logic card);
        nROM_ZONE  = rom;
        nPORT_ZONE = port;
        nCARD_ZONE = card;
    endtask

    task automatic end_cycle();
        nAS = 1'b1;
        PDTACK = 1'b0;
        zones(1'b1, 1'b1, 1'b1);
        step();
    endtask

    initial begin
        nRESET = 1'b0; nAS = 1'b0; nROMWAIT = 1'b1;
        nPWAIT0 = 1'b1; nPWAIT1 = 1'b1; PDTACK = 1'b0; TO_CLR = 1'b0;
        zones(1'b1, 1'b1, 1'b1);
        step();
        chk("rst_ndtack", nDTACK, 1'b1);
        chk("rst_nberr",  nBERR,  1'b1);
        chk("rst_busy",   BUSY,   1'b0);
        chk("rst_flag",   TIMEOUT_FLAG, 1'b0);
        nAS = 1'b1;
        nRESET = 1'b1;
        step();
        chk("idle_busy", BUSY, 1'b0);

        // ROM, one wait
        zones(1'b0, 1'b1, 1'b1); nROMWAIT = 1'b0; nAS = 1'b0;
        step();
        chk("rom1_e0_ndtack", nDTACK, 1'b1);
        chk("rom1_e0_busy",   BUSY,   1'b1);
        step();
        chk("rom1_e1_ndtack", nDTACK, 1'b0);
        chk("rom1_e1_nberr",  nBERR,  1'b1);
        nAS = 1'b1; #1;
        chk("rom1_nas_rise_ndtack", nDTACK, 1'b1);
        chk("rom1_nas_rise_busy",   BUSY,   1'b1);
        step();
        chk("rom1_idle_busy", BUSY, 1'b0);

        // ROM, zero waits, overlapping PORT zone loses on priority
        zones(1'b0, 1'b0, 1'b1); nROMWAIT = 1'b1; nPWAIT0 = 1'b0; nPWAIT1 = 1'b1; nAS = 1'b0;
        step();
        chk("rom0_prio_e0_ndtack", nDTACK, 1'b0);
        end_cycle();

        // PORT N=2, zone/wait inputs changed mid-cycle must be ignored
        zones(1'b1, 1'b0, 1'b1); nPWAIT0 = 1'b0; nPWAIT1 = 1'b1; nAS = 1'b0;
        step();
        chk("port2_e0_ndtack", nDTACK, 1'b1);
        nPWAIT1 = 1'b0; zones(1'b0, 1'b1, 1'b1);
        step();
        chk("port2_e1_ndtack", nDTACK, 1'b1);
        step();
        chk("port2_e2_ndtack", nDTACK, 1'b0);
        end_cycle();
        nPWAIT0 = 1'b1; nPWAIT1 = 1'b1;

        // No zone: zero waits
        nAS = 1'b0;
        step();
        chk("nozone_e0_ndtack", nDTACK, 1'b0);
        // Back-to-back: one IDLE edge then a new cycle decodes
        nAS = 1'b1; step();
        chk("b2b_idle_busy", BUSY, 1'b0);
        nAS = 1'b0; step();
        chk("b2b_e0_ndtack", nDTACK, 1'b0);
        end_cycle();

        // External mode, timeout -> bus error
        zones(1'b1, 1'b0, 1'b1); nPWAIT0 = 1'b0; nPWAIT1 = 1'b0; nAS = 1'b0;
        for (int e = 0; e < 4; e++) begin
            step();
            chk($sformatf("ext_to_e%0d_nberr", e), nBERR, 1'b1);
        end
        step();
        chk("ext_to_e4_nberr",  nBERR,  1'b0);
        chk("ext_to_e4_ndtack", nDTACK, 1'b1);
        chk("ext_to_e4_flag",   TIMEOUT_FLAG, 1'b1);
        nAS = 1'b1; #1;
        chk("ext_to_nas_rise_nberr", nBERR, 1'b1);
        step();
        chk("ext_to_idle_busy", BUSY, 1'b0);
        chk("ext_to_flag_sticky", TIMEOUT_FLAG, 1'b1);
        TO_CLR = 1'b1; step(); TO_CLR = 1'b0;
        chk("to_clr_flag", TIMEOUT_FLAG, 1'b0);

        // External mode, PDTACK before E2
        nAS = 1'b0;
        step(); step();
        PDTACK = 1'b1;
        step();
        chk("ext_ack_e2_ndtack", nDTACK, 1'b0);
        chk("ext_ack_e2_nberr",  nBERR,  1'b1);
        chk("ext_ack_e2_flag",   TIMEOUT_FLAG, 1'b0);
        end_cycle();

        // PDTACK coincident with timeout edge: ack wins
        zones(1'b1, 1'b0, 1'b1); nAS = 1'b0;
        step(); step(); step(); step();
        PDTACK = 1'b1;
        step();
        chk("ext_tie_ndtack", nDTACK, 1'b0);
        chk("ext_tie_nberr",  nBERR,  1'b1);
        chk("ext_tie_flag",   TIMEOUT_FLAG, 1'b0);
        end_cycle();

        // Timeout with TO_CLR on the same edge: set wins
        zones(1'b1, 1'b0, 1'b1); nAS = 1'b0;
        step(); step(); step(); step();
        TO_CLR = 1'b1;
        step();
        TO_CLR = 1'b0;
        chk("setclr_nberr", nBERR, 1'b0);
        chk("setclr_flag",  TIMEOUT_FLAG, 1'b1);
        end_cycle();
        TO_CLR = 1'b1; step(); TO_CLR = 1'b0;
        chk("setclr_cleared", TIMEOUT_FLAG, 1'b0);

        // External mode aborted in EXT
        zones(1'b1, 1'b0, 1'b1); nAS = 1'b0;
        step(); step();
        nAS = 1'b1; step();
        chk("ext_abort_busy", BUSY, 1'b0);
        chk("ext_abort_flag", TIMEOUT_FLAG, 1'b0);
        end_cycle();
        nPWAIT0 = 1'b1; nPWAIT1 = 1'b1;

        // CARD N=2 aborted after E1
        zones(1'b1, 1'b1, 1'b0); nAS = 1'b0;
        step();
        chk("card_abort_e0_ndtack", nDTACK, 1'b1);
        step();
        chk("card_abort_e1_ndtack", nDTACK, 1'b1);
        nAS = 1'b1; step();
        chk("card_abort_busy",   BUSY,   1'b0);
        chk("card_abort_ndtack", nDTACK, 1'b1);
        step();
        chk("card_abort_stay_ndtack", nDTACK, 1'b1);

        // Reset pulse in WAIT, then re-decode with nAS still low
        nAS = 1'b0; step();
        chk("card_rst_pre_busy", BUSY, 1'b1);
        nRESET = 1'b0; #1;
        chk("card_rst_busy",   BUSY,   1'b0);
        chk("card_rst_ndtack", nDTACK, 1'b1);
        chk("card_rst_nberr",  nBERR,  1'b1);
        nRESET = 1'b1;
        step();
        chk("card_rst_redecode_busy",   BUSY,   1'b1);
        chk("card_rst_redecode_ndtack", nDTACK, 1'b1);
        step(); step();
        chk("card_rst_redecode_e2_ndtack", nDTACK, 1'b0);
        // Reset while acknowledging drops nDTACK at once
        nRESET = 1'b0; #1;
        chk("ack_rst_ndtack", nDTACK, 1'b1);
        chk("ack_rst_busy",   BUSY,   1'b0);
        nRESET = 1'b1;
        end_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/c1_cycle_ctrl.md
C1_CYCLE_CTRL -- requirements
Module: c1_cycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, number of 68K clock falling edges an external-ack cycle may last before bus error; legal range 1..15.
REQ-002 CLK_68KCLK  in  1  68K bus clock; all state updates on its falling edge.
REQ-003 nRESET  in  1  reset, asynchronous, active-low.
REQ-004 nAS  in  1  68K address strobe, active-low.
REQ-005 nROM_ZONE, nPORT_ZONE, nCARD_ZONE  in  1 each  decoded zone selects, active-low.
REQ-006 nROMWAIT  in  1  ROM zone wait select: 1 = 0 waits, 0 = 1 wait.
REQ-007 nPWAIT0, nPWAIT1  in  1 each  port zone wait code; N = {~nPWAIT0, ~nPWAIT1}.
REQ-008 PDTACK  in  1  port-device acknowledge, active-high, used only in external mode.
REQ-009 TO_CLR  in  1  synchronous clear of TIMEOUT_FLAG.
REQ-010 nDTACK  out  1  data acknowledge to 68K, active-low.
REQ-011 nBERR  out  1  bus error to 68K, active-low.
REQ-012 BUSY  out  1  high whenever state is not IDLE.
REQ-013 TIMEOUT_FLAG  out  1  sticky, set on every bus-error termination.

Function
REQ-014 States: IDLE, WAIT, EXT, ACK, BERR; 2-bit wait counter WCNT; 4-bit timeout counter TCNT.
REQ-015 IDLE, nAS sampled low: zone and wait code latched once, priority ROM > PORT > CARD > none; later zone/wait input changes ignored until IDLE.
REQ-016 Wait N: ROM = nROMWAIT ? 0 : 1; PORT = code (0..2), code 3 = external mode; CARD = 2; no zone = 0.
REQ-017 N = 0: IDLE -> ACK on the same edge; nDTACK low right after the edge nAS first sampled low (E0).
REQ-018 N > 0: IDLE -> WAIT, WCNT = N; each later edge decrements WCNT; edge with WCNT = 1 -> ACK; nDTACK low after edge E_N.
REQ-019 External mode: IDLE -> EXT, TCNT = 0; each edge in EXT: PDTACK high -> ACK; else TCNT increments; edge where TCNT+1 = TIMEOUT -> BERR.
REQ-020 PDTACK high and timeout on the same edge: ACK wins.
REQ-021 ACK: registered ack = 1; nDTACK = nAS OR NOT ack (combinational), so nDTACK rises as soon as nAS rises.
REQ-022 BERR: registered berr = 1; nBERR = nAS OR NOT berr; nDTACK stays high; TIMEOUT_FLAG set on the entry edge.
REQ-023 ACK/BERR: held until nAS sampled high -> IDLE, ack/berr cleared.
REQ-024 WAIT or EXT with nAS sampled high (aborted cycle) -> IDLE; no ack, no berr, flag unchanged.
REQ-025 nDTACK and nBERR never low together; neither low while nAS high.
REQ-026 TIMEOUT_FLAG: TO_CLR high clears on the edge; set and TO_CLR on same edge -> flag stays 1.
REQ-027 Back-to-back cycles: at least one IDLE edge (nAS high) between cycles; a new cycle is decoded only from IDLE.

Reset
REQ-028 nRESET low asynchronously forces IDLE, WCNT = 0, TCNT = 0, ack = 0, berr = 0, TIMEOUT_FLAG = 0; thus nDTACK = 1, nBERR = 1, BUSY = 0 regardless of nAS.
REQ-029 Reset mid-cycle (any state) aborts the cycle with the same values; after release, a cycle in progress (nAS low) is decoded as new on the next edge only if nAS is sampled low in IDLE.

Verification
REQ-030 ROM zone, nROMWAIT = 0, nAS low at E0 -> nDTACK low after E1, high immediately when nAS rises; BUSY low after next edge.
REQ-031 Port zone, nPWAIT0 = 0, nPWAIT1 = 1 (N = 2) -> nDTACK low after E2; with no zone active -> nDTACK low after E0.
REQ-032 Port zone, code 3, TIMEOUT = 4, PDTACK held 0 -> nBERR low after E4, nDTACK stays 1, TIMEOUT_FLAG = 1; TO_CLR pulse -> flag 0.
REQ-033 Port zone, code 3, PDTACK rises before E2 -> nDTACK low after E2, nBERR stays 1, flag unchanged.
REQ-034 CARD zone (N = 2), nAS released after E1 -> back to IDLE, nDTACK never low; nRESET pulsed in WAIT -> all outputs at reset values immediately.
